// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch requester (IF) and the
// data-access requester (MA). MA has priority; a starvation counter forces an
// IF grant after STARVE_LIMIT consecutive MA grants made while IF was waiting.
// Each grant latches the owner's command, holds ow_mem_req until iw_mem_ack or
// timeout, then returns a one-cycle ack (with read data) or err to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_ack,
  output logic              ow_if_err,
  output logic [DATA_W-1:0] ow_if_rdata,
  input  logic              iw_ma_req,
  input  logic              iw_ma_we,
  input  logic [ADDR_W-1:0] iw_ma_addr,
  input  logic [DATA_W-1:0] iw_ma_wdata,
  output logic              ow_ma_ack,
  output logic              ow_ma_err,
  output logic [DATA_W-1:0] ow_ma_rdata,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_ack,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic              ow_busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_MA = 2'd2;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              TO_EN      = (TIMEOUT_CYC > 0);

  logic [1:0]      state;
  logic [SC_W-1:0] starve_cnt;
  logic [TO_W-1:0] to_cnt;

  logic if_elig;
  logic ma_elig;
  logic pick_ma;
  logic pick_if;
  logic timeout_hit;

  // Arbitration: a requester whose ack/err pulse is still showing is not
  // eligible, so a requester finishing this cycle cannot be re-granted at once.
  always_comb begin
    if_elig     = iw_if_req && !ow_if_ack && !ow_if_err;
    ma_elig     = iw_ma_req && !ow_ma_ack && !ow_ma_err;
    pick_ma     = ma_elig && (!if_elig || (starve_cnt != STARVE_MAX));
    pick_if     = if_elig && !pick_ma;
    timeout_hit = TO_EN && (to_cnt == TO_LAST);
  end

  assign ow_busy = (state != IDLE);

  // Grant FSM, command latch, memory handshake and owner responses.
  // NOTE: every register here uses non-blocking assignment so all of them update
  // from the same pre-edge values; reset clears all state since there is no memory array.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      to_cnt       <= '0;
      ow_if_ack    <= 1'b0;
      ow_if_err    <= 1'b0;
      ow_if_rdata  <= '0;
      ow_ma_ack    <= 1'b0;
      ow_ma_err    <= 1'b0;
      ow_ma_rdata  <= '0;
      ow_mem_req   <= 1'b0;
      ow_mem_we    <= 1'b0;
      ow_mem_addr  <= '0;
      ow_mem_wdata <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless re-raised below.
      ow_if_ack <= 1'b0;
      ow_if_err <= 1'b0;
      ow_ma_ack <= 1'b0;
      ow_ma_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_ma) begin
            state        <= GNT_MA;
            ow_mem_req   <= 1'b1;
            ow_mem_we    <= iw_ma_we;
            ow_mem_addr  <= iw_ma_addr;
            ow_mem_wdata <= iw_ma_wdata;
            to_cnt       <= '0;
            if (iw_if_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (pick_if) begin
            state        <= GNT_IF;
            ow_mem_req   <= 1'b1;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= iw_if_addr;
            ow_mem_wdata <= '0;
            to_cnt       <= '0;
            starve_cnt   <= '0;
          end
        end

        GNT_IF, GNT_MA: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (iw_mem_ack) begin
            state      <= IDLE;
            ow_mem_req <= 1'b0;
            if (state == GNT_IF) begin
              ow_if_ack   <= 1'b1;
              ow_if_rdata <= iw_mem_rdata;
            end else begin
              ow_ma_ack <= 1'b1;
              if (!ow_mem_we)
                ow_ma_rdata <= iw_mem_rdata;
            end
          end else if (timeout_hit) begin
            state      <= IDLE;
            ow_mem_req <= 1'b0;
            if (state == GNT_IF)
              ow_if_err <= 1'b1;
            else
              ow_ma_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
